// File: rtl/projectile_pool.sv
// Per-player ball engine: shoot edges spawn balls; balls move per tick, despawn at END_X or on hit. Optional PROJECTILE_AUTO_FIRE_EN.
// Latency: shoot edge -> ball_EN 1 clk; hit/drop pulses registered, 1 clk after the causing edge.
// Backpressure: none; requests during cooldown or with no free slot are discarded (the latter flagged on drop_pulse).
module projectile_pool #(
    parameter int NUM_SLOTS = 12,
    parameter int DIR       = 0,
    parameter int SPAWN_X   = 17,
    parameter int END_X     = 95,
    parameter int STEP      = 2,
    parameter int HIT_X     = 72,
    parameter int HIT_H     = 14,
    parameter int SPAWN_DY  = 6,
    parameter int COOLDOWN  = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tick,
    input  logic                     shoot,
    input  logic [5:0]               shooter_topY,
    input  logic                     shooter_alive,
    input  logic [5:0]               target_topY,
    input  logic                     target_alive,
    output logic [NUM_SLOTS-1:0]     ball_EN,
    output logic [NUM_SLOTS*7-1:0]   leftX_bus,
    output logic [NUM_SLOTS*6-1:0]   topY_bus,
    output logic                     hit_pulse,
    output logic [3:0]               hit_count,
    output logic                     drop_pulse
);

    localparam logic [7:0] SPAWN_X8  = 8'(SPAWN_X);
    localparam logic [7:0] END_X8    = 8'(END_X);
    localparam logic [7:0] STEP8     = 8'(STEP);
    localparam logic [7:0] HIT_X8    = 8'(HIT_X);
    localparam logic [7:0] HIT_H8    = 8'(HIT_H);
    localparam logic [6:0] SPAWN_DY7 = 7'(SPAWN_DY);
    localparam logic [7:0] COOLDOWN8 = 8'(COOLDOWN);

    logic [NUM_SLOTS-1:0] en_q;
    logic [6:0]           lx_q [NUM_SLOTS];
    logic [5:0]           ty_q [NUM_SLOTS];
    logic [7:0]           cd_q;
    logic                 shoot_q;

    logic [7:0]           nx [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] hit_v;
    logic [NUM_SLOTS-1:0] gone_v;
    logic [4:0]           hit_sum;
    logic [3:0]           hit_cnt;
    logic                 edge_req;
    logic                 fire_ok;
    logic                 have_free;
    logic [3:0]           free_idx;
    logic [6:0]           spawn_sum;
    logic [5:0]           spawn_ty;
    logic [7:0]           lx_ext;
    logic [5:0]           dy;
    logic                 past_hit;
    logic                 at_end;

    always_comb begin
        hit_v    = '0;
        gone_v   = '0;
        hit_sum  = '0;
        lx_ext   = '0;
        dy       = '0;
        past_hit = 1'b0;
        at_end   = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            lx_ext = {1'b0, lx_q[i]};
            if (DIR == 0) begin
                nx[i]    = lx_ext + STEP8;
                past_hit = (nx[i] >= HIT_X8);
                // the 8-bit sum catches balls that would wrap the 7-bit column
                at_end   = (nx[i] >= END_X8) || (nx[i] > 8'd127);
            end else begin
                nx[i]    = (lx_ext >= STEP8) ? (lx_ext - STEP8) : 8'd0;
                past_hit = (nx[i] <= HIT_X8);
                at_end   = (nx[i] <= END_X8);
            end
            dy = (ty_q[i] >= target_topY) ? (ty_q[i] - target_topY) : (target_topY - ty_q[i]);
            hit_v[i]  = tick && en_q[i] && target_alive && past_hit && ({2'b00, dy} < HIT_H8);
            gone_v[i] = tick && en_q[i] && !hit_v[i] && at_end;
            hit_sum   = hit_sum + 5'(hit_v[i]);
        end
        hit_cnt = (hit_sum > 5'd15) ? 4'd15 : hit_sum[3:0];
    end

    always_comb begin
        edge_req = shoot && !shoot_q;
`ifdef PROJECTILE_AUTO_FIRE_EN
        // held shoot refires on the tick that brings the cooldown to zero
        fire_ok  = shooter_alive && ((edge_req && (cd_q == 8'd0)) ||
                                     (shoot && tick && (cd_q <= 8'd1)));
`else
        fire_ok  = shooter_alive && edge_req && (cd_q == 8'd0);
`endif
        have_free = 1'b0;
        free_idx  = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!en_q[i]) begin
                have_free = 1'b1;
                free_idx  = 4'(i);
            end
        end
        spawn_sum = {1'b0, shooter_topY} + SPAWN_DY7;
        spawn_ty  = (spawn_sum > 7'd63) ? 6'd63 : spawn_sum[5:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q       <= '0;
            cd_q       <= '0;
            shoot_q    <= 1'b0;
            hit_pulse  <= 1'b0;
            hit_count  <= '0;
            drop_pulse <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                lx_q[i] <= SPAWN_X8[6:0];
                ty_q[i] <= '0;
            end
        end else begin
            shoot_q    <= shoot;
            hit_pulse  <= (hit_cnt != 4'd0);
            hit_count  <= hit_cnt;
            drop_pulse <= fire_ok && !have_free;
            if (fire_ok && have_free)
                cd_q <= COOLDOWN8;
            else if (tick && (cd_q != 8'd0))
                cd_q <= cd_q - 8'd1;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (hit_v[i] || gone_v[i])
                    en_q[i] <= 1'b0;
                else if (tick && en_q[i])
                    lx_q[i] <= nx[i][6:0];
                // only a slot that was free at the start of the cycle can be claimed
                if (fire_ok && have_free && (free_idx == 4'(i))) begin
                    en_q[i] <= 1'b1;
                    lx_q[i] <= SPAWN_X8[6:0];
                    ty_q[i] <= spawn_ty;
                end
            end
        end
    end

    assign ball_EN = en_q;

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_bus
        assign leftX_bus[7*g +: 7] = lx_q[g];
        assign topY_bus[6*g +: 6]  = ty_q[g];
    end

endmodule
